// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate at the
// terminal count, wrap pulse and invalid-load pulse.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  carry_out,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] clamped;
  logic                bad_digit;
  logic                ripple;
  logic                all9;
  logic                all0;
  logic [3:0]          d;
  logic [3:0]          ld;

  // One-cycle ripple: each digit steps only while every lower digit rolls over.
  always_comb begin
    stepped = count;
    ripple  = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    d       = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = count[4*k +: 4];
      if (d != 4'd9) all9 = 1'b0;
      if (d != 4'd0) all0 = 1'b0;
      if (ripple) begin
        if (up) begin
          if (d >= 4'd9) begin
            stepped[4*k +: 4] = 4'd0;
          end else begin
            stepped[4*k +: 4] = d + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*k +: 4] = 4'd9;
          end else begin
            stepped[4*k +: 4] = d - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped   = load_value;
    bad_digit = 1'b0;
    ld        = '0;
    for (int k = 0; k < DIGITS; k++) begin
      ld = load_value[4*k +: 4];
      if (ld > 4'd9) begin
        clamped[4*k +: 4] = 4'd9;
        bad_digit = 1'b1;
      end
    end
  end

  assign tc = up ? all9 : all0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        count    <= clamped;
        load_err <= bad_digit;
      end else if (en) begin
        if (!tc) begin
          count <= stepped;
        end else if (WRAP) begin
          // At the terminal value the ripple naturally yields all-0 / all-9.
          count     <= stepped;
          carry_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: four instances (4-digit wrap/saturate, 1 and 8 digit)
// driven in lockstep and compared each cycle against an integer reference model.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [31:0] lv;
  logic [15:0] c0, c1;
  logic [3:0]  c2;
  logic [31:0] c3;
  logic [3:0]  tcv, cov, lev;

  int checks = 0;
  int errors = 0;

  int mval[4];
  bit mcarry[4];
  bit merr[4];
  int dg[4] = '{4, 4, 1, 8};
  bit wr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int wraps2, wraps3;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut0 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(lv[15:0]), .count(c0), .tc(tcv[0]), .carry_out(cov[0]), .load_err(lev[0]));
  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) dut1 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(lv[15:0]), .count(c1), .tc(tcv[1]), .carry_out(cov[1]), .load_err(lev[1]));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) dut2 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(lv[3:0]), .count(c2), .tc(tcv[2]), .carry_out(cov[2]), .load_err(lev[2]));
  bcd_counter_n #(.DIGITS(8), .WRAP(1'b1)) dut3 (.clk(clk), .reset(reset), .en(en), .up(up),
    .load(load), .load_value(lv), .count(c3), .tc(tcv[3]), .carry_out(cov[3]), .load_err(lev[3]));

  function automatic int pow10(int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] obs_count(int i);
    case (i)
      0: return {16'h0, c0};
      1: return {16'h0, c1};
      2: return {28'h0, c2};
      default: return c3;
    endcase
  endfunction

  function automatic bit digits_ok(logic [31:0] v, int n);
    for (int k = 0; k < n; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: the count is an ordinary integer modulo 10^DIGITS.
  task automatic model_update(int i);
    int top = pow10(dg[i]) - 1;
    int dec;
    logic [3:0] nib;
    if (reset) begin
      mval[i] = 0; mcarry[i] = 0; merr[i] = 0;
    end else begin
      mcarry[i] = 0; merr[i] = 0;
      if (load) begin
        dec = 0;
        for (int k = 0; k < dg[i]; k++) begin
          nib = lv[4*k +: 4];
          if (nib > 4'd9) begin nib = 4'd9; merr[i] = 1; end
          dec = dec + int'(nib) * pow10(k);
        end
        mval[i] = dec;
      end else if (en) begin
        if (up) begin
          if (mval[i] == top) begin
            if (wr[i]) begin mval[i] = 0; mcarry[i] = 1; end
          end else mval[i] = mval[i] + 1;
        end else begin
          if (mval[i] == 0) begin
            if (wr[i]) begin mval[i] = top; mcarry[i] = 1; end
          end else mval[i] = mval[i] - 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit etc;
    for (int i = 0; i < 4; i++) model_update(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      etc = up ? (mval[i] == pow10(dg[i]) - 1) : (mval[i] == 0);
      chk($sformatf("count%0d", i), obs_count(i), to_bcd(mval[i], dg[i]));
      chk($sformatf("carry%0d", i), {31'h0, cov[i]}, {31'h0, mcarry[i]});
      chk($sformatf("lerr%0d", i), {31'h0, lev[i]}, {31'h0, merr[i]});
      chk($sformatf("tc%0d", i), {31'h0, tcv[i]}, {31'h0, etc});
      chk($sformatf("digits%0d", i), {31'h0, digits_ok(obs_count(i), dg[i])}, 32'h1);
    end
    if (cov[2]) wraps2++;
    if (cov[3]) wraps3++;
  endtask

  task automatic drive(bit r, bit l, bit e, bit u, logic [31:0] v);
    reset = r; load = l; en = e; up = u; lv = v;
  endtask

  initial begin
    drive(1, 1, 1, 1, 32'h5555_5555);
    cycle();
    chk("rst_count", {16'h0, c0}, 32'h0000);
    chk("rst_carry", {31'h0, cov[0]}, 32'h0);
    // Load with en: load only, no step
    drive(0, 1, 1, 1, 32'h5555_5555);
    cycle();
    chk("prio_load", {16'h0, c0}, 32'h5555);

    // Up wrap
    drive(0, 1, 0, 1, 32'h0000_9998);
    cycle();
    drive(0, 0, 1, 1, 32'h0);
    cycle();
    chk("upw_9999", {16'h0, c0}, 32'h9999);
    chk("upw_tc", {31'h0, tcv[0]}, 32'h1);
    cycle();
    chk("upw_0000", {16'h0, c0}, 32'h0000);
    chk("upw_carry", {31'h0, cov[0]}, 32'h1);
    cycle();
    chk("upw_0001", {16'h0, c0}, 32'h0001);
    chk("upw_carry_lo", {31'h0, cov[0]}, 32'h0);

    // Down borrow chain and down wrap
    drive(0, 1, 0, 0, 32'h0000_1000);
    cycle();
    drive(0, 0, 1, 0, 32'h0);
    cycle();
    chk("dn_0999", {16'h0, c0}, 32'h0999);
    drive(0, 1, 0, 0, 32'h0);
    cycle();
    drive(0, 0, 1, 0, 32'h0);
    cycle();
    chk("dnw_9999", {16'h0, c0}, 32'h9999);
    chk("dnw_carry", {31'h0, cov[0]}, 32'h1);

    // Saturation on the WRAP=0 instance
    drive(0, 1, 0, 1, 32'h9999_9999);
    cycle();
    drive(0, 0, 1, 1, 32'h0);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("sat_hold", {16'h0, c1}, 32'h9999);
      chk("sat_carry", {31'h0, cov[1]}, 32'h0);
    end
    drive(0, 0, 1, 0, 32'h0);
    cycle();
    chk("sat_dn", {16'h0, c1}, 32'h9998);

    // Invalid load clamping
    drive(0, 1, 0, 1, 32'h0000_A3F7);
    cycle();
    chk("inv_count", {16'h0, c0}, 32'h9397);
    chk("inv_err", {31'h0, lev[0]}, 32'h1);
    drive(0, 0, 0, 1, 32'h0);
    cycle();
    chk("inv_err_once", {31'h0, lev[0]}, 32'h0);
    drive(0, 1, 0, 1, 32'h0000_1234);
    cycle();
    chk("val_count", {16'h0, c0}, 32'h1234);
    chk("val_err", {31'h0, lev[0]}, 32'h0);

    // Randomised phase
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: lv = 32'h9999_9998;
        1: lv = 32'h0000_0001;
        default: lv = $urandom;
      endcase
      reset = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = 1'($urandom);
      cycle();
    end

    // 1-digit free run: 12 cycles from 0 gives exactly one wrap
    drive(1, 0, 0, 1, 32'h0);
    cycle();
    wraps2 = 0;
    drive(0, 0, 1, 1, 32'h0);
    for (int n = 0; n < 12; n++) cycle();
    chk("d1_wraps", wraps2, 32'd1);

    // 8-digit window across 99999999 -> 0
    drive(0, 1, 0, 1, 32'h9999_9990);
    cycle();
    wraps3 = 0;
    drive(0, 0, 1, 1, 32'h0);
    for (int n = 0; n < 20; n++) cycle();
    chk("d8_wraps", wraps3, 32'd1);
    chk("d8_count", c3, 32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 en  input  1  count enable; count steps once per cycle while high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_value  input  4*DIGITS  load data; digit k in bits [4k+3:4k], digit 0 is least significant.
REQ-009 count  output  4*DIGITS  registered BCD count, same digit packing as load_value.
REQ-010 tc  output  1  combinational terminal-count flag for the current direction.
REQ-011 carry_out  output  1  registered one-cycle pulse on wrap-around.
REQ-012 load_err  output  1  registered one-cycle pulse on a load containing a non-BCD digit.

Function
REQ-013 Each rising clk SHALL apply the first matching rule: reset, then load, then en, then hold.
REQ-014 Up-count SHALL increment digit 0. A digit at 9 SHALL go to 0 and carry into the next digit.
REQ-015 Down-count SHALL decrement digit 0. A digit at 0 SHALL go to 9 and borrow from the next digit.
REQ-016 Terminal value SHALL be all digits 9 when up=1 and all digits 0 when up=0.
REQ-017 tc SHALL be high exactly when count equals the terminal value for the current up, independent of en.
REQ-018 With WRAP=1, en=1 and tc=1, count SHALL wrap:
- up: all-9 -> all-0;
- down: all-0 -> all-9.
REQ-019 carry_out SHALL be high in the cycle after a wrap step and low otherwise.
REQ-020 With WRAP=0, en=1 and tc=1, count SHALL hold and carry_out SHALL stay low.
REQ-021 On load, any digit of load_value greater than 9 SHALL be stored as 9. Valid digits SHALL be stored unchanged.
REQ-022 load_err SHALL be high in the cycle after a load in which at least one digit was clamped. It SHALL be low otherwise.
REQ-023 load with en=1 in the same cycle SHALL perform only the load: no count step, carry_out low.
REQ-024 A direction change SHALL take effect on the next enabled edge with no extra latency.
REQ-025 Latency from en to updated count SHALL be one clock. The step SHALL be a single-cycle ripple across all DIGITS digits.
REQ-026 count SHALL never hold a digit value above 9 after reset.

Reset
REQ-027 With reset high at a rising clk:
- count SHALL become all zeros;
- carry_out and load_err SHALL become 0.
REQ-028 reset SHALL override load and en in the same cycle. A count or load in progress SHALL be discarded.
REQ-029 Before the first reset edge, output values are undefined. tc SHALL be valid from the first cycle after reset.

Verification (DIGITS=4 unless noted)
REQ-030 Up wrap, WRAP=1: load 0x9998, then en=1, up=1 for 3 cycles. count SHALL read 0x9999, 0x0000, 0x0001. carry_out SHALL be high only with 0x0000. tc SHALL be high only at 0x9999.
REQ-031 Down borrow chain, WRAP=1: load 0x1000, then en=1, up=0 for 1 cycle. count SHALL be 0x0999. Then load 0x0000 and step down once. count SHALL be 0x9999 and carry_out SHALL pulse.
REQ-032 Saturation, WRAP=0: load 0x9999 and hold en=1, up=1 for 5 cycles. count SHALL stay 0x9999 with tc=1 and carry_out=0. Then set up=0. The next edge SHALL give 0x9998.
REQ-033 Invalid load: load_value=0xA3F7. count SHALL be 0x9397 and load_err SHALL pulse for exactly one cycle. A following load of 0x1234 SHALL give load_err=0.
REQ-034 Priority: assert reset, load=1 (0x5555) and en=1 in the same cycle. count SHALL be 0x0000. Next cycle, load=1 and en=1 SHALL give count 0x5555 with no step.
REQ-035 Parameter sweep: DIGITS=1 and DIGITS=8. Free-run up from 0 for 10^DIGITS+2 cycles (DIGITS=1) or a sampled window across the 99999999 -> 0 wrap (DIGITS=8). Every digit SHALL stay at 9 or below and carry_out SHALL pulse once per wrap.
